// File: rtl/lmk_sysref_seq.sv
// LMK SYNC/SYSREF sequencer: SYNC pulse, gap, then counted or continuous SYSREF,
// with busy/done handshake. All outputs registered in the FMC core clock domain.
module lmk_sysref_seq #(
    parameter int HP_W = 8,
    parameter int BL_W = 8,
    parameter int SL_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            cfg_continuous,
    input  logic [HP_W-1:0] cfg_half_period,
    input  logic [BL_W-1:0] cfg_burst_len,
    input  logic [SL_W-1:0] cfg_sync_len,
    input  logic [SL_W-1:0] cfg_gap,
    output logic            lmk_sync_out,
    output logic            sysref_out,
    output logic            busy,
    output logic            done,
    output logic [BL_W-1:0] pulse_cnt
);

    localparam logic [HP_W-1:0] HP_ZERO = {HP_W{1'b0}};
    localparam logic [HP_W-1:0] HP_ONE  = {{(HP_W-1){1'b0}}, 1'b1};
    localparam logic [BL_W-1:0] BL_ZERO = {BL_W{1'b0}};
    localparam logic [BL_W-1:0] BL_ONE  = {{(BL_W-1){1'b0}}, 1'b1};
    localparam logic [SL_W-1:0] SL_ZERO = {SL_W{1'b0}};
    localparam logic [SL_W-1:0] SL_ONE  = {{(SL_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_GAP    = 3'd2,
        ST_SYSREF = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic            cont_r;
    logic [HP_W-1:0] hp_r, ph_r;
    logic [BL_W-1:0] bl_r, pulse_cnt_r;
    logic [SL_W-1:0] sl_r, gap_r, len_cnt_r;
    logic            lvl_r;
    logic            sync_r, sysref_r, busy_r, done_r;
    logic            sync_d, sysref_d, busy_d, done_d;

    logic            accept_s, fall_s, burst_end_s, idle_empty_s, lat_empty_s;
    logic [HP_W-1:0] hp_last_s;

    // A half period of 0 behaves as 1, so the wrap point is clamped at 0.
    assign hp_last_s    = (hp_r == HP_ZERO) ? HP_ZERO : (hp_r - HP_ONE);
    assign accept_s     = (state_r == ST_IDLE) && start && !abort;
    assign fall_s       = (state_r == ST_SYSREF) && (ph_r == hp_last_s) && lvl_r;
    assign burst_end_s  = fall_s && !cont_r && ((pulse_cnt_r + BL_ONE) == bl_r);
    assign idle_empty_s = !cfg_continuous && (cfg_burst_len == BL_ZERO);
    assign lat_empty_s  = !cont_r && (bl_r == BL_ZERO);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_s = state_r;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!start) begin
                        state_s = ST_IDLE;
                    end else if (cfg_sync_len != SL_ZERO) begin
                        state_s = ST_SYNC;
                    end else if (cfg_gap != SL_ZERO) begin
                        state_s = ST_GAP;
                    end else if (idle_empty_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SYSREF;
                    end
                end
                ST_SYNC: begin
                    if (len_cnt_r != (sl_r - SL_ONE)) begin
                        state_s = ST_SYNC;
                    end else if (gap_r != SL_ZERO) begin
                        state_s = ST_GAP;
                    end else if (lat_empty_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SYSREF;
                    end
                end
                ST_GAP: begin
                    if (len_cnt_r != (gap_r - SL_ONE)) begin
                        state_s = ST_GAP;
                    end else if (lat_empty_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SYSREF;
                    end
                end
                ST_SYSREF: begin
                    if (burst_end_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SYSREF;
                    end
                end
                ST_DONE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Output decode; registered below so each pin lags its state by one cycle.
    always_comb begin
        sync_d   = (state_r == ST_SYNC)   && !abort;
        sysref_d = (state_r == ST_SYSREF) && lvl_r && !abort;
        busy_d   = (state_r != ST_IDLE)   && !abort;
        done_d   = (state_r == ST_DONE)   && !abort;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r   <= 1'b0;
            sysref_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            sync_r   <= sync_d;
            sysref_r <= sysref_d;
            busy_r   <= busy_d;
            done_r   <= done_d;
        end
    end

    // Config latch, length/gap counter, SYSREF phase generator and pulse counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cont_r      <= 1'b0;
            hp_r        <= HP_ZERO;
            bl_r        <= BL_ZERO;
            sl_r        <= SL_ZERO;
            gap_r       <= SL_ZERO;
            len_cnt_r   <= SL_ZERO;
            ph_r        <= HP_ZERO;
            lvl_r       <= 1'b0;
            pulse_cnt_r <= BL_ZERO;
        end else begin
            if (accept_s) begin
                cont_r <= cfg_continuous;
                hp_r   <= cfg_half_period;
                bl_r   <= cfg_burst_len;
                sl_r   <= cfg_sync_len;
                gap_r  <= cfg_gap;
            end
            if ((state_s == state_r) && ((state_r == ST_SYNC) || (state_r == ST_GAP))) begin
                len_cnt_r <= len_cnt_r + SL_ONE;
            end else begin
                len_cnt_r <= SL_ZERO;
            end
            if ((state_r == ST_SYSREF) && (state_s == ST_SYSREF)) begin
                if (ph_r == hp_last_s) begin
                    ph_r  <= HP_ZERO;
                    lvl_r <= ~lvl_r;
                end else begin
                    ph_r  <= ph_r + HP_ONE;
                end
            end else begin
                ph_r  <= HP_ZERO;
                lvl_r <= 1'b0;
            end
            if (accept_s) begin
                pulse_cnt_r <= BL_ZERO;
            end else if (fall_s && !abort) begin
                pulse_cnt_r <= pulse_cnt_r + BL_ONE;
            end
        end
    end

    assign lmk_sync_out = sync_r;
    assign sysref_out   = sysref_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign pulse_cnt    = pulse_cnt_r;

endmodule

// File: doc/lmk_sysref_seq.md
Name: lmk_sysref_seq

Overview:
- Sequencer for the LMK SYNC and SYSREF signals shared by the two FMC120 cards (master and slave).
- Replaces the free-running core-clock divider and the software-toggled GPIO sync line.
- Runs in the 250 MHz FMC core clock domain. Its outputs feed the common lmk_sync_in and lmk_sysref_in inputs of both fmc120 instances.
- Produces a programmable SYNC pulse, a programmable gap, then either a counted SYSREF burst or continuous SYSREF, with a busy/done handshake back to the control logic.

Parameters:
- HP_W, 8, width of the SYSREF half-period field.
- BL_W, 8, width of the burst-length field.
- SL_W, 16, width of the SYNC-length and gap fields.

Ports:
- clk  input  1  FMC core clock (fmc_core_clk_0 domain); all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a sequence; sampled only in IDLE.
- abort  input  1  level; forces return to IDLE.
- cfg_continuous  input  1  0 = counted burst, 1 = continuous SYSREF until abort.
- cfg_half_period  input  HP_W  SYSREF high time and low time, in clk cycles; 0 is treated as 1.
- cfg_burst_len  input  BL_W  number of SYSREF pulses in burst mode.
- cfg_sync_len  input  SL_W  SYNC assertion length in cycles.
- cfg_gap  input  SL_W  idle cycles between SYNC deassertion and the SYSREF phase.
- lmk_sync_out  output  1  SYNC to the LMK, active high, registered.
- sysref_out  output  1  SYSREF to the LMK, registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a burst completes.
- pulse_cnt  output  BL_W  SYSREF pulses emitted in the current or last sequence; wraps in continuous mode.

Behaviour:
- Reset: all outputs are 0, state is IDLE, counters are 0. Reset is asynchronous on assertion; release is on the next clk edge.
- Config latch: all cfg_* inputs are captured into internal registers on the cycle start is accepted. Config changes during a sequence have no effect.
- State IDLE:
  - start=1 and abort=0 clears pulse_cnt.
  - Next state is SYNC if sync_len>0, else GAP if gap>0, else SYSREF.
  - start=1 and abort=1 in the same cycle: abort wins and start is ignored.
- State SYNC:
  - lmk_sync_out=1 for exactly sync_len cycles, the first of which is the cycle after start is sampled.
  - Then goes to GAP, or to SYSREF if gap=0.
- State GAP: both outputs low for exactly gap cycles, then SYSREF.
- State SYSREF:
  - On entry, sysref_out=0 and the phase counter is 0.
  - The phase counter runs 0..H-1; at H-1 it reloads and sysref_out toggles. The result is H cycles low, H high, H low, and so on.
  - pulse_cnt increments on each falling edge of sysref_out.
  - Burst mode: on the falling edge that completes pulse burst_len, go to DONE. sysref_out is low from that cycle on.
  - burst_len=0 in burst mode: go directly to DONE with no pulse.
  - Continuous mode: stays in SYSREF until abort.
- State DONE:
  - One cycle: done=1, busy=1. Next state is IDLE, where done=0 and busy=0.
- abort asserted in any non-IDLE state:
  - Next cycle: state is IDLE and lmk_sync_out=0, sysref_out=0, busy=0.
  - No done pulse; pulse_cnt holds its value.
- start while busy: ignored, not queued.
- Counter widths: the phase counter is HP_W bits and the length/gap counters are SL_W bits. No overflow is possible given the latched limits.
- Latency from start sample to first SYSREF rising edge: sync_len + gap + H + 1 cycles.

Test Plan:
- Reset: assert rst_n=0 mid-burst (asynchronously, between clock edges) -> all outputs 0 immediately. Release -> IDLE, busy=0.
- Burst, H=2, burst_len=3, sync_len=4, gap=5, start sampled at edge 0:
  - lmk_sync_out high cycles 1-4.
  - sysref_out high cycles 12-13, 16-17, 20-21.
  - done=1 at cycle 22; busy low at cycle 23; pulse_cnt=3.
- Degenerate config, H=0, sync_len=0, gap=0, burst_len=1 -> sysref_out high cycle 2 only, done at cycle 3.
- Degenerate config, burst_len=0 -> done at cycle 1 and no pulse.
- Continuous mode, H=32, run 10 pulses (a 64-cycle period matching the legacy 3.9 MHz SYSREF), then abort -> outputs low and busy low next cycle, no done, pulse_cnt=10.
- Start while busy, plus config changed mid-burst -> ignored; original timing preserved.
- Start and abort asserted in the same IDLE cycle -> remains IDLE.
- Start one cycle after done -> new sequence accepted, pulse_cnt cleared.
